// File: rtl/circuito_jogo_param.sv
// Memory-game round controller: replays a loadable sequence of plays against the switches,
// reporting win, wrong play or per-play timeout. Sequence length is short (modo=0) or full (modo=1).
module circuito_jogo_param #(
  parameter int N_CHAVES    = 4,
  parameter int DEPTH       = 16,
  parameter int N_MODO0     = 4,
  parameter int TIMEOUT_CYC = 3000,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                modo,
  input  logic [N_CHAVES-1:0] chaves,
  input  logic                mem_we,
  input  logic [AW-1:0]       mem_addr,
  input  logic [N_CHAVES-1:0] mem_data,
  output logic                acertou,
  output logic                errou,
  output logic                timeout,
  output logic                pronto,
  output logic [N_CHAVES-1:0] leds,
  output logic [3:0]          db_estado,
  output logic [AW-1:0]       db_contagem
);

  typedef enum logic [3:0] {
    S_INICIAL     = 4'h0,
    S_PREPARA     = 4'h1,
    S_ESPERA      = 4'h2,
    S_REGISTRA    = 4'h3,
    S_COMPARA     = 4'h4,
    S_PROXIMO     = 4'h5,
    S_FIM_ACERTO  = 4'hA,
    S_FIM_ERRO    = 4'hE,
    S_FIM_TIMEOUT = 4'hF
  } estado_t;

  localparam logic [TW-1:0] T_MAX      = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : TW'(0);
  localparam logic [AW-1:0] LAST_MODO0 = AW'(N_MODO0 - 1);
  localparam logic [AW-1:0] LAST_MODO1 = AW'(DEPTH - 1);

  estado_t             state_q, state_d;
  logic [AW-1:0]       index_q, index_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                modo_q, modo_d;
  logic [N_CHAVES-1:0] play_q, play_d;
  logic [N_CHAVES-1:0] chaves_prev_q;
  logic                acertou_q, acertou_d;
  logic                errou_q, errou_d;
  logic                timeout_q, timeout_d;
  logic                pronto_q, pronto_d;

  logic [N_CHAVES-1:0] mem_q [DEPTH];

  logic                tem_jogada_s;
  logic                mem_wr_ok_s;
  logic [AW-1:0]       last_idx_s;
  logic [N_CHAVES-1:0] mem_rd_s;

  assign tem_jogada_s = (chaves != '0) && (chaves_prev_q == '0);
  assign last_idx_s   = modo_q ? LAST_MODO1 : LAST_MODO0;
  assign mem_rd_s     = mem_q[index_q];
  assign mem_wr_ok_s  = (state_q == S_INICIAL) || (state_q == S_FIM_ACERTO) ||
                        (state_q == S_FIM_ERRO) || (state_q == S_FIM_TIMEOUT);

  // Next-state, datapath updates and Moore output decode
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    timer_d = timer_q;
    modo_d  = modo_q;
    play_d  = play_q;
    case (state_q)
      S_INICIAL: begin
        if (iniciar) state_d = S_PREPARA;
        else         state_d = S_INICIAL;
      end
      S_PREPARA: begin
        index_d = '0;
        timer_d = '0;
        modo_d  = modo;
        play_d  = '0;
        state_d = S_ESPERA;
      end
      S_ESPERA: begin
        if (timer_q != T_MAX) timer_d = timer_q + TW'(1);
        else                  timer_d = timer_q;
        // a play arriving on the last timer cycle still counts
        if (tem_jogada_s) begin
          play_d  = chaves;
          state_d = S_REGISTRA;
        end else if ((TIMEOUT_CYC != 0) && (timer_q == T_MAX)) begin
          state_d = S_FIM_TIMEOUT;
        end else begin
          state_d = S_ESPERA;
        end
      end
      S_REGISTRA: state_d = S_COMPARA;
      S_COMPARA: begin
        if (play_q != mem_rd_s)          state_d = S_FIM_ERRO;
        else if (index_q == last_idx_s)  state_d = S_FIM_ACERTO;
        else                             state_d = S_PROXIMO;
      end
      S_PROXIMO: begin
        index_d = index_q + AW'(1);
        timer_d = '0;
        state_d = S_ESPERA;
      end
      S_FIM_ACERTO, S_FIM_ERRO, S_FIM_TIMEOUT: begin
        if (iniciar) state_d = S_PREPARA;
        else         state_d = state_q;
      end
      default: state_d = S_INICIAL;
    endcase

    acertou_d = (state_d == S_FIM_ACERTO);
    timeout_d = (state_d == S_FIM_TIMEOUT);
    errou_d   = (state_d == S_FIM_ERRO) || timeout_d;
    pronto_d  = acertou_d || errou_d;
  end

  // Control state, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_INICIAL;
      index_q       <= '0;
      timer_q       <= '0;
      modo_q        <= 1'b0;
      play_q        <= '0;
      chaves_prev_q <= '0;
      acertou_q     <= 1'b0;
      errou_q       <= 1'b0;
      timeout_q     <= 1'b0;
      pronto_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      timer_q       <= timer_d;
      modo_q        <= modo_d;
      play_q        <= play_d;
      chaves_prev_q <= chaves;
      acertou_q     <= acertou_d;
      errou_q       <= errou_d;
      timeout_q     <= timeout_d;
      pronto_q      <= pronto_d;
    end
  end

  // Sequence memory survives reset; writes only land while no round is running
  always_ff @(posedge clock) begin
    if (mem_we && mem_wr_ok_s) mem_q[mem_addr] <= mem_data;
  end

  assign acertou     = acertou_q;
  assign errou       = errou_q;
  assign timeout     = timeout_q;
  assign pronto      = pronto_q;
  assign leds        = play_q;
  assign db_estado   = state_q;
  assign db_contagem = index_q;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Self-checking bench for circuito_jogo_param: vector table, hand-written corner sequences,
// and randomized rounds scored by a round-level reference model.
module tb_circuito_jogo_param;

  localparam int NC = 4;
  localparam int DP = 16;
  localparam int NM0 = 4;
  localparam int TO = 50;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          iniciar;
  logic          modo;
  logic [NC-1:0] chaves;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [NC-1:0] mem_data;
  logic          acertou, errou, timeout, pronto;
  logic [NC-1:0] leds;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_contagem;

  int total = 0;
  int bad = 0;

  logic [NC-1:0] ref_mem [DP];

  typedef struct {
    bit          modo;
    bit          flip_modo;
    int          n_plays;
    int          bad_at;
    logic [3:0]  bad_val;
    logic [3:0]  exp_estado;
    int          exp_cont;
    bit          exp_ac;
    bit          exp_er;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t vecs [6];

  circuito_jogo_param #(
    .N_CHAVES(NC), .DEPTH(DP), .N_MODO0(NM0), .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .chaves(chaves),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
    .leds(leds), .db_estado(db_estado), .db_contagem(db_contagem)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_end(input string name, input logic [3:0] est, input int cont,
                           input bit ac, input bit er, input bit to, input logic [3:0] ld);
    check({name, ".estado"}, 32'(db_estado), 32'(est));
    check({name, ".contagem"}, 32'(db_contagem), 32'(cont));
    check({name, ".acertou"}, 32'(acertou), 32'(ac));
    check({name, ".errou"}, 32'(errou), 32'(er));
    check({name, ".timeout"}, 32'(timeout), 32'(to));
    check({name, ".pronto"}, 32'(pronto), 32'(ac | er));
    check({name, ".leds"}, 32'(leds), 32'(ld));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic start_round(input bit m);
    modo = m;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
  endtask

  task automatic apply_play(input logic [NC-1:0] v, input int hi, input int lo);
    chaves = v;
    repeat (hi) step();
    chaves = '0;
    repeat (lo) step();
  endtask

  task automatic write_mem(input int a, input logic [NC-1:0] d);
    mem_we = 1'b1;
    mem_addr = AW'(a);
    mem_data = d;
    step();
    mem_we = 1'b0;
  endtask

  task automatic wait_pronto(input string name, input int budget);
    int n = 0;
    while (!pronto && n < budget) begin
      step();
      n++;
    end
    if (!pronto) check({name, ".pronto_wait"}, 32'(pronto), 32'd1);
  endtask

  function automatic logic [NC-1:0] pat(input int i);
    logic [NC-1:0] one = 4'b0001;
    return one << (i % 4);
  endfunction

  initial begin
    int regs;
    reset = 1'b1; iniciar = 1'b0; modo = 1'b0; chaves = '0;
    mem_we = 1'b0; mem_addr = '0; mem_data = '0;

    vecs[0] = '{1'b0, 1'b0,  4, -1, 4'h0, 4'hA,  3, 1'b1, 1'b0, 4'h8};
    vecs[1] = '{1'b1, 1'b0,  5,  4, 4'h2, 4'hE,  4, 1'b0, 1'b1, 4'h2};
    vecs[2] = '{1'b0, 1'b0,  1,  0, 4'h3, 4'hE,  0, 1'b0, 1'b1, 4'h3};
    vecs[3] = '{1'b1, 1'b1, 16, -1, 4'h0, 4'hA, 15, 1'b1, 1'b0, 4'h8};
    vecs[4] = '{1'b0, 1'b0,  4,  3, 4'h4, 4'hE,  3, 1'b0, 1'b1, 4'h4};
    vecs[5] = '{1'b1, 1'b0, 16, 15, 4'h1, 4'hE, 15, 1'b0, 1'b1, 4'h1};

    do_reset();
    check_end("reset", 4'h0, 0, 1'b0, 1'b0, 1'b0, 4'h0);

    for (int i = 0; i < DP; i++) begin
      write_mem(i, pat(i));
      ref_mem[i] = pat(i);
    end

    // Table-driven rounds
    for (int v = 0; v < 6; v++) begin
      start_round(vecs[v].modo);
      if (vecs[v].flip_modo) modo = ~modo;
      for (int i = 0; i < vecs[v].n_plays; i++)
        apply_play((i == vecs[v].bad_at) ? vecs[v].bad_val : pat(i), 10, 10);
      wait_pronto($sformatf("vec%0d", v), 20);
      check_end($sformatf("vec%0d", v), vecs[v].exp_estado, vecs[v].exp_cont,
                vecs[v].exp_ac, vecs[v].exp_er, 1'b0, vecs[v].exp_leds);
    end

    // Play latency and exact timeout instant
    start_round(1'b0);
    chaves = 4'b0001;
    step();
    check("lat.registra", 32'(db_estado), 32'h3);
    chaves = '0;
    step();
    check("lat.compara", 32'(db_estado), 32'h4);
    step();
    check("lat.proximo", 32'(db_estado), 32'h5);
    check("lat.pronto_low", 32'(pronto), 32'd0);
    step();
    check("to.espera", 32'(db_estado), 32'h2);
    repeat (TO - 1) step();
    check("to.still_espera", 32'(db_estado), 32'h2);
    step();
    check_end("to", 4'hF, 1, 1'b0, 1'b1, 1'b1, 4'h1);

    // Held switches count as a single play
    start_round(1'b0);
    chaves = 4'b0001;
    regs = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (db_estado == 4'h3) regs++;
    end
    chaves = '0;
    check("hold.plays", 32'(regs), 32'd1);
    check("hold.contagem", 32'(db_contagem), 32'd1);
    check("hold.estado", 32'(db_estado), 32'h2);

    // Reset mid-round, memory retained
    do_reset();
    start_round(1'b0);
    apply_play(pat(0), 10, 10);
    apply_play(pat(1), 10, 10);
    check("rst.pre_idx", 32'(db_contagem), 32'd2);
    check("rst.pre_est", 32'(db_estado), 32'h2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_end("rst", 4'h0, 0, 1'b0, 1'b0, 1'b0, 4'h0);
    start_round(1'b0);
    for (int i = 0; i < NM0; i++) apply_play(pat(i), 10, 10);
    check_end("rst.mem", 4'hA, 3, 1'b1, 1'b0, 1'b0, 4'h8);

    // Write during ESPERA is ignored
    start_round(1'b0);
    write_mem(0, 4'b1000);
    apply_play(4'b0001, 5, 5);
    check("we.contagem", 32'(db_contagem), 32'd1);
    check("we.errou", 32'(errou), 32'd0);
    for (int i = 1; i < NM0; i++) apply_play(pat(i), 5, 5);
    check_end("we", 4'hA, 3, 1'b1, 1'b0, 1'b0, 4'h8);

    // Randomized rounds against a round-level model
    for (int r = 0; r < 30; r++) begin
      logic [NC-1:0] plays [DP];
      bit m;
      int len, stop_at, end_at;
      logic [3:0] e_est;
      logic [NC-1:0] e_leds;

      for (int i = 0; i < DP; i++) begin
        ref_mem[i] = ($urandom_range(0, 1) == 0) ? pat($urandom_range(0, 3))
                                                 : NC'($urandom_range(1, 15));
        write_mem(i, ref_mem[i]);
      end
      m = ($urandom_range(0, 3) == 0);
      len = m ? DP : NM0;
      for (int i = 0; i < len; i++)
        plays[i] = ($urandom_range(0, 7) != 0) ? ref_mem[i] : NC'($urandom_range(1, 15));
      stop_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : len;

      e_est = 4'hA;
      end_at = len - 1;
      e_leds = '0;
      for (int i = 0; i < len; i++) begin
        if (i == stop_at) begin
          e_est = 4'hF; end_at = i; break;
        end
        e_leds = plays[i];
        if (plays[i] != ref_mem[i]) begin
          e_est = 4'hE; end_at = i; break;
        end
      end

      start_round(m);
      modo = $urandom_range(0, 1);
      for (int i = 0; i < len; i++) begin
        if (i == stop_at) break;
        apply_play(plays[i], $urandom_range(1, 4), $urandom_range(3, 6));
        if (i == end_at) break;
      end
      wait_pronto($sformatf("rnd%0d", r), TO + 20);
      check_end($sformatf("rnd%0d", r), e_est, end_at, e_est == 4'hA,
                e_est != 4'hA, e_est == 4'hF, e_leds);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
